// File: rtl/fp24_pkg.sv
// rtl/fp24_pkg.sv - shared float-word and op-tag types for the float core arbiter
package fp24_pkg;
    localparam int FP_W     = 24;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 15;
    // Tag ids are sized for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef logic [FP_W-1:0] fp24_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } op_tag_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts at ptr_i and wraps
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     gnt_idx_o,
    output logic               any_o
);
    logic [IDW-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(ptr_i) + k) % NUM_REQ);
            if (!any_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
                any_o      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fp_op_arbiter.sv
// rtl/fp_op_arbiter.sv - shares one pipelined float core between requesters, routes results back by tag
module fp_op_arbiter
    import fp24_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FW      = 24,
    parameter int LATENCY = 3,
    parameter int IDW     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*FW-1:0]  req_a,
    input  logic [NUM_REQ*FW-1:0]  req_b,
    output logic                   core_valid,
    output logic [FW-1:0]          core_a,
    output logic [FW-1:0]          core_b,
    input  logic [FW-1:0]          core_result,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [FW-1:0]          rsp_data,
    output logic [IDW+LATENCY-1:0] inflight
);
    localparam int IW = IDW + LATENCY;

    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_any;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [FW-1:0]      sel_a, sel_b;
    logic [FW-1:0]      core_a_q, core_b_q;
    logic               core_valid_q;
    op_tag_t            tag_q [LATENCY+1];
    op_tag_t            tag_out;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q;
    logic [FW-1:0]      rsp_data_q;
    logic [IW-1:0]      inflight_q, inflight_d;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
        .req_i     (hold ? '0 : req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    // Grants are suppressed while reset is asserted so requesters never see a phantom handshake.
    assign req_ready = rst ? gnt : '0;
    assign ptr_d     = gnt_any ? IDW'((int'(gnt_idx) + 1) % NUM_REQ) : ptr_q;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[i*FW +: FW];
                sel_b = req_b[i*FW +: FW];
            end
        end
    end

    // tag_q[0] runs alongside core_valid; tag_q[LATENCY] lines up with core_result.
    assign tag_out     = tag_q[LATENCY];
    assign rsp_valid_d = tag_out.valid ? (NUM_REQ'(1) << tag_out.id) : '0;
    assign inflight_d  = inflight_q + IW'(gnt_any) - IW'(|rsp_valid_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q        <= '0;
            core_valid_q <= 1'b0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
            rsp_valid_q  <= '0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            inflight_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            core_valid_q <= gnt_any;
            if (gnt_any) begin
                core_a_q <= sel_a;
                core_b_q <= sel_b;
            end
            tag_q[0].valid <= gnt_any;
            tag_q[0].id    <= TAG_ID_W'(gnt_idx);
            for (int k = 1; k <= LATENCY; k++) tag_q[k] <= tag_q[k-1];
            rsp_valid_q <= rsp_valid_d;
            if (tag_out.valid) begin
                rsp_id_q   <= IDW'(tag_out.id);
                rsp_data_q <= core_result;
            end
            inflight_q <= inflight_d;
        end
    end

    assign core_valid = core_valid_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign inflight   = inflight_q;
endmodule

// File: tb/tb_fp_op_arbiter.sv
// tb/tb_fp_op_arbiter.sv - scoreboard bench for fp_op_arbiter with an adder core model
module tb_fp_op_arbiter;
    localparam int N   = 4;
    localparam int FW  = 24;
    localparam int L   = 3;
    localparam int IDW = 2;
    localparam int IW  = IDW + L;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            hold = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*FW-1:0] req_a = '0;
    logic [N*FW-1:0] req_b = '0;
    logic            core_valid;
    logic [FW-1:0]   core_a, core_b, core_result;
    logic [N-1:0]    rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [FW-1:0]   rsp_data;
    logic [IW-1:0]   inflight;

    fp_op_arbiter #(.NUM_REQ(N), .FW(FW), .LATENCY(L), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .core_valid(core_valid), .core_a(core_a), .core_b(core_b), .core_result(core_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .inflight(inflight)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: plain 24-bit add of the raw words, LATENCY cycles after core_valid.
    logic [FW-1:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= core_valid ? core_a + core_b : '0;
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign core_result = pipe[L-1];

    typedef struct { int due; logic [FW-1:0] a; logic [FW-1:0] b; } iss_t;
    typedef struct { int due; int id; logic [FW-1:0] d; } rsp_t;
    iss_t iss_q[$];
    rsp_t rsp_q[$];
    iss_t ie;
    rsp_t re;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr_idx(input logic [N-1:0] v, input int p);
        logic [IDW-1:0] j;
        for (int k = 0; k < N; k++) begin
            j = IDW'((p + k) % N);
            if (v[j]) return int'(j);
        end
        return -1;
    endfunction

    // Reference arbiter: predicts grants and inflight, pushes expected issue/response.
    int            mptr = 0;
    int            minf = 0;
    int            gi;
    logic [N-1:0]  eg;
    logic [L+1:0]  hist = '0;
    always @(negedge clk) begin
        if (!rst) begin
            mptr = 0; minf = 0; hist = '0;
            iss_q.delete(); rsp_q.delete();
        end else begin
            gi = hold ? -1 : rr_idx(req_valid, mptr);
            eg = (gi < 0) ? '0 : (N'(1) << gi);
            check("req_ready", 32'(req_ready), 32'(eg));
            check("inflight", 32'(inflight), minf);
            if (gi >= 0) begin
                iss_q.push_back('{cyc + 1, req_a[gi*FW +: FW], req_b[gi*FW +: FW]});
                rsp_q.push_back('{cyc + L + 2, gi, req_a[gi*FW +: FW] + req_b[gi*FW +: FW]});
                mptr = (gi + 1) % N;
            end
            minf = minf + ((gi >= 0) ? 1 : 0) - (hist[L+1] ? 1 : 0);
            hist = {hist[L:0], gi >= 0};
        end
    end

    // Monitor: compares whatever the DUT presents against the scoreboard heads.
    always @(negedge clk) begin
        if (rst) begin
            if (core_valid || (iss_q.size() > 0 && iss_q[0].due == cyc)) begin
                if (iss_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL core_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    ie = iss_q.pop_front();
                    check("core_valid", 32'(core_valid), 1);
                    check("issue_cycle", cyc, ie.due);
                    check("core_a", 32'(core_a), 32'(ie.a));
                    check("core_b", 32'(core_b), 32'(ie.b));
                end
            end
            if (rsp_valid != '0 || (rsp_q.size() > 0 && rsp_q[0].due == cyc)) begin
                if (rsp_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL rsp_valid: got %0h expected 0 (cycle %0d)", rsp_valid, cyc);
                end else begin
                    re = rsp_q.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(N'(1) << re.id));
                    check("rsp_cycle", cyc, re.due);
                    check("rsp_id", 32'(rsp_id), re.id);
                    check("rsp_data", 32'(rsp_data), 32'(re.d));
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*FW +: FW] = FW'(24'h400000 + 24'h1111 * (i + 1) + 24'h10 * cyc);
            req_b[i*FW +: FW] = FW'(24'h3F0000 + 24'h0202 * (i + 1));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_core_valid"}, 32'(core_valid), 0);
        check({tag, "_core_a"}, 32'(core_a), 0);
        check({tag, "_core_b"}, 32'(core_b), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 0);
        check({tag, "_inflight"}, 32'(inflight), 0);
    endtask

    initial begin
        // Reset state, with requests pending to confirm grants are gated.
        req_valid = 4'b1111;
        #2 check_zero("reset");
        tick(2);
        req_valid = '0;
        tick();
        rst = 1'b1;

        // Single op from requester 0.
        tick();
        req_a[0 +: FW] = 24'h414000;
        req_b[0 +: FW] = 24'h3E8000;
        req_valid = 4'b0001;
        #2 check("t1_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #2 check("t1_core_valid", 32'(core_valid), 1);
        check("t1_core_a", 32'(core_a), 32'h414000);
        check("t1_core_b", 32'(core_b), 32'h3E8000);
        tick(4);
        #2 check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1_rsp_id", 32'(rsp_id), 0);
        check("t1_rsp_data", 32'(rsp_data), 32'h7FC000);

        // All requesters continuously valid; steady-state inflight is LATENCY+2.
        tick();
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            set_ops();
            tick();
            if (k >= 4) check("full_inflight", 32'(inflight), 5);
        end
        req_valid = '0;
        tick(8);
        check("drain_inflight", 32'(inflight), 0);

        // Four-op burst with a 3-cycle hold in the middle.
        req_valid = 4'b1111;
        set_ops();
        tick(2);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2 check("hold_ready", 32'(req_ready), 0);
            tick();
        end
        hold = 1'b0;
        tick(2);
        req_valid = '0;
        tick(8);
        check("hold_drain", 32'(inflight), 0);

        // Round-robin wrap: park ptr at 2, then req1+req3 -> 3 then 1, ptr back at 2.
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1010;
        #2 check("rr_first", 32'(req_ready), 32'h8);
        tick();
        #2 check("rr_wrap", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b1111;
        #2 check("rr_ptr2", 32'(req_ready), 32'h4);
        tick();

        // Lone requester granted every cycle.
        req_valid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            #2 check("lone_grant", 32'(req_ready), 32'h4);
            tick();
        end
        req_valid = '0;
        tick(8);

        // Reset with three ops in flight.
        req_valid = 4'b1111;
        set_ops();
        tick(3);
        req_valid = '0;
        #2 rst = 1'b0;
        #1 check_zero("midrst");
        tick();
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #2 check("post_rst_rsp", 32'(rsp_valid), 0);
            tick();
        end
        check("post_rst_inflight", 32'(inflight), 0);
        check("queue_drained", rsp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
